// File: rtl/uart_pkg.sv
// uart_pkg: shared types and timing helper for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE2} uart_parity_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: word handshake between a byte source and the UART transmitter
// parity_mode is present only when UART_TX_PARITY_EN is defined.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
`ifdef UART_TX_PARITY_EN
    uart_parity_t         parity_mode;

    modport master (output tx_data, tx_valid, parity_mode, input tx_ready);
    modport slave  (input tx_data, tx_valid, parity_mode, output tx_ready);
`else
    modport master (output tx_data, tx_valid, input tx_ready);
    modport slave  (input tx_data, tx_valid, output tx_ready);
`endif

endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter with restart, flags the last and next-to-last cycle of a bit
module uart_baud_gen #(
    parameter int CPB = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_end,
    output logic almost_end
);
    localparam int CW = $clog2(CPB);

    logic [CW-1:0] cnt;

    assign bit_end    = cnt == CW'(CPB - 1);
    assign almost_end = cnt == CW'(CPB - 2);

    always_ff @(posedge clk) begin
        if (rst || restart || bit_end)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter (start, data LSB first, optional parity, stop bits)
// Parity support and the parity_mode signal are compiled in with UART_TX_PARITY_EN.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_param_if.slave bus,
    output logic           tx,
    output logic           tx_busy
);
    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int IW  = $clog2(DATA_BITS);

    if (CPB < 2) begin : g_cpb_chk
        $error("uart_tx_param: CLKS_PER_BIT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_chk
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    uart_tx_state_t       state, state_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic                 ready, ready_n, tx_n, accept, bit_end, almost_end;
`ifdef UART_TX_PARITY_EN
    logic                 par, par_n, par_en, par_en_n;
`endif

    assign accept       = bus.tx_valid & ready;
    assign bus.tx_ready = ready;

    uart_baud_gen #(.CPB(CPB)) u_baud (
        .clk        (clk),
        .rst        (rst),
        .restart    (accept),
        .bit_end    (bit_end),
        .almost_end (almost_end)
    );

    always_comb begin
        state_n = state;
        idx_n   = idx;
        sh_n    = accept ? bus.tx_data : sh;
`ifdef UART_TX_PARITY_EN
        par_n    = accept ? (^bus.tx_data) ^ (bus.parity_mode == PAR_ODD) : par;
        par_en_n = accept ? (bus.parity_mode == PAR_EVEN || bus.parity_mode == PAR_ODD) : par_en;
`endif
        case (state)
            IDLE:   state_n = accept ? START : IDLE;
            START: begin
                state_n = bit_end ? DATA : START;
                idx_n   = '0;
            end
            DATA: if (bit_end) begin
                sh_n  = sh >> 1;
                idx_n = idx + IW'(1);
                if (idx == IW'(DATA_BITS - 1)) begin
                    idx_n = '0;
`ifdef UART_TX_PARITY_EN
                    state_n = par_en ? PARITY : STOP;
`else
                    state_n = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: state_n = bit_end ? STOP : PARITY;
`endif
            STOP: if (bit_end) begin
                idx_n = idx + IW'(1);
                if (idx == IW'(STOP_BITS - 1))
                    state_n = accept ? START : IDLE;
            end
            default: state_n = IDLE;
        endcase
        tx_n = (state_n == START) ? 1'b0 : (state_n == DATA) ? sh_n[0] : 1'b1;
`ifdef UART_TX_PARITY_EN
        if (state_n == PARITY)
            tx_n = par_n;
`endif
        // ready is registered, so raise it one cycle ahead of the final stop cycle
        ready_n = (state_n == IDLE) ||
                  (state_n == STOP && idx_n == IW'(STOP_BITS - 1) && almost_end);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            sh      <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            ready   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
            par_en  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            sh      <= sh_n;
            tx      <= tx_n;
            tx_busy <= state_n != IDLE;
            ready   <= ready_n;
`ifdef UART_TX_PARITY_EN
            par     <= par_n;
            par_en  <= par_en_n;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: randomized self-checking bench for uart_tx_param at 10 clocks per bit
// Parity scenarios run only when UART_TX_PARITY_EN is defined.
module tb_uart_tx_param;
    import uart_pkg::*;

    localparam int CF  = 1_000_000;
    localparam int BR  = 100_000;
    localparam int CPB = CF / BR;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx0, busy0, tx1, busy1;
    logic [1:0] pm_drv = 2'd0;
    int         total = 0;
    int         bad = 0;

    uart_tx_param_if #(.DATA_BITS(8)) if0 ();
    uart_tx_param_if #(.DATA_BITS(5)) if1 ();

`ifdef UART_TX_PARITY_EN
    assign if0.parity_mode = uart_parity_t'(pm_drv);
    assign if1.parity_mode = PAR_NONE;
`endif

    uart_tx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .bus(if0), .tx(tx0), .tx_busy(busy0)
    );

    uart_tx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(5), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .bus(if1), .tx(tx1), .tx_busy(busy1)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is a list of bit values, each lasting CPB cycles
    function automatic bit par_on(input logic [1:0] pm);
        return PAR_EN && (pm == 2'd1 || pm == 2'd2);
    endfunction

    function automatic int flen(input int nd, input int ns, input logic [1:0] pm);
        return CPB * (1 + nd + (par_on(pm) ? 1 : 0) + ns);
    endfunction

    function automatic logic exp_tx(input logic [8:0] d, input int nd, input logic [1:0] pm, input int k);
        int b;
        logic [8:0] t;
        b = k / CPB;
        if (b == 0) return 1'b0;
        if (b <= nd) begin
            t = d >> (b - 1);
            return t[0];
        end
        if (b == nd + 1 && par_on(pm)) return (^d) ^ (pm == 2'd2);
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        if0.tx_valid = 1'b0;
        if1.tx_valid = 1'b0;
        if0.tx_data = '0;
        if1.tx_data = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({tx0, busy0, if0.tx_ready} !== 3'b100) begin
            bad++;
            $display("FAIL reset0: tx/busy/ready=%b expected 100", {tx0, busy0, if0.tx_ready});
        end
        total++;
        if ({tx1, busy1, if1.tx_ready} !== 3'b100) begin
            bad++;
            $display("FAIL reset1: tx/busy/ready=%b expected 100", {tx1, busy1, if1.tx_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({tx0, busy0, if0.tx_ready, tx1, busy1, if1.tx_ready} !== 6'b101101) begin
            bad++;
            $display("FAIL release: got=%b expected 101101", {tx0, busy0, if0.tx_ready, tx1, busy1, if1.tx_ready});
        end
    endtask

    task automatic test_a5();
        int len;
        pm_drv = 2'd0;
        len = flen(8, 1, pm_drv);
        if0.tx_data = 8'hA5;
        if0.tx_valid = 1'b1;
        @(negedge clk);
        if0.tx_valid = 1'b0;
        for (int k = 0; k < len; k++) begin
            total++;
            if (tx0 !== exp_tx(9'h0A5, 8, pm_drv, k) || busy0 !== 1'b1 || if0.tx_ready !== (k == len - 1)) begin
                bad++;
                $display("FAIL a5 k=%0d: tx=%b busy=%b ready=%b, expected tx=%b busy=1 ready=%b",
                         k, tx0, busy0, if0.tx_ready, exp_tx(9'h0A5, 8, pm_drv, k), k == len - 1);
            end
            @(negedge clk);
        end
        total++;
        if ({tx0, busy0, if0.tx_ready} !== 3'b101) begin
            bad++;
            $display("FAIL a5_idle: tx/busy/ready=%b expected 101", {tx0, busy0, if0.tx_ready});
        end
    endtask

    task automatic test_back_to_back();
        int len;
        int rdy_cnt;
        logic [8:0] w;
        pm_drv = 2'd0;
        len = flen(8, 1, pm_drv);
        rdy_cnt = 0;
        if0.tx_data = 8'h00;
        if0.tx_valid = 1'b1;
        @(negedge clk);
        if0.tx_data = 8'hFF;
        for (int k = 0; k < 2 * len; k++) begin
            w = (k < len) ? 9'h000 : 9'h0FF;
            if (if0.tx_ready === 1'b1) rdy_cnt++;
            total++;
            if (tx0 !== exp_tx(w, 8, pm_drv, k % len) || busy0 !== 1'b1 || if0.tx_ready !== (k % len == len - 1)) begin
                bad++;
                $display("FAIL b2b k=%0d: tx=%b busy=%b ready=%b, expected tx=%b busy=1 ready=%b",
                         k, tx0, busy0, if0.tx_ready, exp_tx(w, 8, pm_drv, k % len), k % len == len - 1);
            end
            if (k == len) if0.tx_valid = 1'b0;
            @(negedge clk);
        end
        total++;
        if (rdy_cnt !== 2) begin
            bad++;
            $display("FAIL b2b_ready_pulses: got=%0d expected 2", rdy_cnt);
        end
        total++;
        if ({tx0, busy0, if0.tx_ready} !== 3'b101) begin
            bad++;
            $display("FAIL b2b_idle: tx/busy/ready=%b expected 101", {tx0, busy0, if0.tx_ready});
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int len;
        for (int i = 0; i < 2; i++) begin
            pm_drv = (i == 0) ? 2'd1 : 2'd2;
            len = flen(8, 1, pm_drv);
            if0.tx_data = 8'h07;
            if0.tx_valid = 1'b1;
            @(negedge clk);
            if0.tx_valid = 1'b0;
            for (int k = 0; k < len; k++) begin
                total++;
                if (tx0 !== exp_tx(9'h007, 8, pm_drv, k) || busy0 !== 1'b1 || if0.tx_ready !== (k == len - 1)) begin
                    bad++;
                    $display("FAIL parity mode=%0d k=%0d: tx=%b busy=%b ready=%b, expected tx=%b busy=1 ready=%b",
                             pm_drv, k, tx0, busy0, if0.tx_ready, exp_tx(9'h007, 8, pm_drv, k), k == len - 1);
                end
                @(negedge clk);
            end
            total++;
            if (busy0 !== 1'b0) begin
                bad++;
                $display("FAIL parity_len mode=%0d: busy=%b after %0d cycles, expected 0", pm_drv, busy0, len);
            end
        end
    endtask
`endif

    task automatic test_five_bits();
        int len;
        len = flen(5, 2, 2'd0);
        if1.tx_data = 5'h1F;
        if1.tx_valid = 1'b1;
        @(negedge clk);
        if1.tx_valid = 1'b0;
        for (int k = 0; k < len; k++) begin
            total++;
            if (tx1 !== exp_tx(9'h01F, 5, 2'd0, k) || busy1 !== 1'b1 || if1.tx_ready !== (k == len - 1)) begin
                bad++;
                $display("FAIL five k=%0d: tx=%b busy=%b ready=%b, expected tx=%b busy=1 ready=%b",
                         k, tx1, busy1, if1.tx_ready, exp_tx(9'h01F, 5, 2'd0, k), k == len - 1);
            end
            @(negedge clk);
        end
        total++;
        if ({tx1, busy1, if1.tx_ready} !== 3'b101) begin
            bad++;
            $display("FAIL five_idle: tx/busy/ready=%b expected 101", {tx1, busy1, if1.tx_ready});
        end
    endtask

    task automatic test_reset_mid();
        int len;
        logic [7:0] w;
        pm_drv = 2'd0;
        if0.tx_data = 8'h3C;
        if0.tx_valid = 1'b1;
        @(negedge clk);
        if0.tx_valid = 1'b0;
        for (int k = 0; k < CPB * 4; k++) begin
            total++;
            if (tx0 !== exp_tx(9'h03C, 8, pm_drv, k)) begin
                bad++;
                $display("FAIL pre_rst k=%0d: tx=%b expected %b", k, tx0, exp_tx(9'h03C, 8, pm_drv, k));
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({tx0, busy0, if0.tx_ready} !== 3'b100) begin
            bad++;
            $display("FAIL mid_rst: tx/busy/ready=%b expected 100", {tx0, busy0, if0.tx_ready});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({tx0, busy0, if0.tx_ready} !== 3'b101) begin
            bad++;
            $display("FAIL mid_rst_release: tx/busy/ready=%b expected 101", {tx0, busy0, if0.tx_ready});
        end
        w = 8'($urandom);
        pm_drv = 2'($urandom);
        len = flen(8, 1, pm_drv);
        if0.tx_data = w;
        if0.tx_valid = 1'b1;
        @(negedge clk);
        if0.tx_valid = 1'b0;
        for (int k = 0; k < len; k++) begin
            total++;
            if (tx0 !== exp_tx({1'b0, w}, 8, pm_drv, k) || busy0 !== 1'b1) begin
                bad++;
                $display("FAIL post_rst k=%0d: tx=%b busy=%b, expected tx=%b busy=1",
                         k, tx0, busy0, exp_tx({1'b0, w}, 8, pm_drv, k));
            end
            @(negedge clk);
        end
        total++;
        if ({tx0, busy0, if0.tx_ready} !== 3'b101) begin
            bad++;
            $display("FAIL post_rst_idle: tx/busy/ready=%b expected 101", {tx0, busy0, if0.tx_ready});
        end
    endtask

    task automatic test_busy_ignore();
        int len;
        logic [7:0] w;
        logic [1:0] pm;
        for (int f = 0; f < 4; f++) begin
            w = 8'($urandom);
            pm = 2'($urandom);
            pm_drv = pm;
            len = flen(8, 1, pm);
            if0.tx_data = w;
            if0.tx_valid = 1'b1;
            @(negedge clk);
            for (int k = 0; k < len; k++) begin
                total++;
                if (tx0 !== exp_tx({1'b0, w}, 8, pm, k) || busy0 !== 1'b1 || if0.tx_ready !== (k == len - 1)) begin
                    bad++;
                    $display("FAIL ignore f=%0d k=%0d: tx=%b busy=%b ready=%b, expected tx=%b busy=1 ready=%b",
                             f, k, tx0, busy0, if0.tx_ready, exp_tx({1'b0, w}, 8, pm, k), k == len - 1);
                end
                if0.tx_data = 8'($urandom);
                pm_drv = 2'($urandom);
                if0.tx_valid = (k < len - 1) ? 1'($urandom) : 1'b0;
                @(negedge clk);
            end
            for (int k = 0; k < 2 * CPB; k++) begin
                total++;
                if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
                    bad++;
                    $display("FAIL ignore_idle f=%0d k=%0d: tx=%b busy=%b, expected tx=1 busy=0", f, k, tx0, busy0);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_a5();
        test_back_to_back();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_five_bits();
        test_reset_mid();
        test_busy_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
